// File: rtl/csa_acc_pkg.sv
// csa_acc_pkg -- shared types and default widths for the carry-save accumulator.
//   state_t : controller states (IDLE, ACCUM, RESOLVE, DONE)
//   W_DEF   : default operand/result width
//   CW_DEF  : default operand-count field width
package csa_acc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int W_DEF  = 41;
    localparam int CW_DEF = 8;

endpackage

// File: rtl/csa_cell.sv
// csa_cell -- W-bit 3:2 compressor (one row of full adders), purely combinational.
// Ports:
//   a_i, b_i, c_i : three W-bit addends
//   sum_o         : bitwise sum vector
//   carry_o       : majority vector shifted up one bit (bit 0 is 0)
//   msb_co_o      : majority of bit W-1, which falls off the top of carry_o
module csa_cell
    import csa_acc_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o,
    output logic         msb_co_o
);

    logic [W-1:0] maj;

    always_comb begin
        sum_o    = a_i ^ b_i ^ c_i;
        maj      = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
        carry_o  = {maj[W-2:0], 1'b0};
        msb_co_o = maj[W-1];
    end

endmodule

// File: rtl/csa_acc_ctrl.sv
// csa_acc_ctrl -- accumulates a counted stream of W-bit operands in carry-save
// form (S, C) and resolves S+C with one carry-propagate add at the end.
// Optional feature: define CSA_ACC_OVF_EN to add the ovf output.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start, op_cnt     : begin a job of op_cnt operands (sampled in IDLE only)
//   clear             : synchronous abort to IDLE, wins over everything else
//   op_valid/op_ready : operand stream handshake, op_data is the operand
//   res_valid/res_ready, res_data : result handshake, sum modulo 2^W
//   busy              : high outside IDLE
//   ovf               : (CSA_ACC_OVF_EN only) true sum >= 2^W, valid with res_valid
module csa_acc_ctrl
    import csa_acc_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] op_cnt,
    input  logic          clear,
    input  logic          op_valid,
    input  logic [W-1:0]  op_data,
    output logic          op_ready,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_data,
    output logic          busy
`ifdef CSA_ACC_OVF_EN
    ,
    output logic          ovf
`endif
);

    state_t        state_q, state_d;
    logic [W-1:0]  s_q, s_d;
    logic [W-1:0]  c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  res_q, res_d;

    logic [W-1:0]  cell_sum;
    logic [W-1:0]  cell_carry;

`ifdef CSA_ACC_OVF_EN
    logic          ovf_q, ovf_d;
    logic          cell_msb;
    logic [W:0]    resolve_sum;
`else
    logic          cell_msb_unused;
    logic [W-1:0]  resolve_sum;
`endif

    csa_cell #(.W(W)) u_cell (
        .a_i      (s_q),
        .b_i      (c_q),
        .c_i      (op_data),
        .sum_o    (cell_sum),
        .carry_o  (cell_carry),
`ifdef CSA_ACC_OVF_EN
        .msb_co_o (cell_msb)
`else
        .msb_co_o (cell_msb_unused)
`endif
    );

    // Final carry-propagate add; the extra bit is the overflow carry when enabled.
`ifdef CSA_ACC_OVF_EN
    assign resolve_sum = {1'b0, s_q} + {1'b0, c_q};
`else
    assign resolve_sum = s_q + c_q;
`endif

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
`ifdef CSA_ACC_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (clear) begin
            state_d = IDLE;
            s_d     = '0;
            c_d     = '0;
            cnt_d   = '0;
`ifdef CSA_ACC_OVF_EN
            ovf_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_d   = op_cnt;
                        s_d     = '0;
                        c_d     = '0;
`ifdef CSA_ACC_OVF_EN
                        ovf_d   = 1'b0;
`endif
                        state_d = (op_cnt == '0) ? RESOLVE : ACCUM;
                    end
                end
                ACCUM: begin
                    // op_ready is high throughout ACCUM, so op_valid alone accepts.
                    if (op_valid) begin
                        s_d   = cell_sum;
                        c_d   = cell_carry;
                        cnt_d = cnt_q - CW'(1);
`ifdef CSA_ACC_OVF_EN
                        ovf_d = ovf_q | cell_msb;
`endif
                        if (cnt_q == CW'(1)) state_d = RESOLVE;
                    end
                end
                RESOLVE: begin
                    res_d   = resolve_sum[W-1:0];
`ifdef CSA_ACC_OVF_EN
                    ovf_d   = ovf_q | resolve_sum[W];
`endif
                    state_d = DONE;
                end
                DONE: begin
                    if (res_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
`ifdef CSA_ACC_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
`ifdef CSA_ACC_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign op_ready  = (state_q == ACCUM);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_data  = res_q;
`ifdef CSA_ACC_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_csa_acc_ctrl.sv
// tb_csa_acc_ctrl -- directed and randomized jobs against a plain-integer sum model.
module tb_csa_acc_ctrl;

    localparam int W  = 41;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] op_cnt;
    logic          clear;
    logic          op_valid;
    logic [W-1:0]  op_data;
    logic          op_ready;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic          busy;
`ifdef CSA_ACC_OVF_EN
    logic          ovf;
`endif

    int tests = 0;
    int fails = 0;
    logic [W-1:0] ops[$];

    csa_acc_ctrl #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_cnt    (op_cnt),
        .clear     (clear),
        .op_valid  (op_valid),
        .op_data   (op_data),
        .op_ready  (op_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
`ifdef CSA_ACC_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(3))
            0:       return r[W-1:0];
            1:       return {W{1'b1}};
            2:       return W'(r[7:0]);
            default: return {1'b1, r[W-2:0]};
        endcase
    endfunction

    // Runs one job using the operands in ops; the model is just the integer sum.
    task automatic run_job(input string tag, input int cnt, input int vpct, input int hold);
        logic [63:0] true_sum;
        logic [W-1:0] held;
        int idx;
        int guard;
        bit stable;
        true_sum = '0;
        idx      = 0;
        guard    = 0;
        start    = 1'b1;
        op_cnt   = CW'(cnt);
        tick();
        chk({tag, "/busy_after_start"}, busy, 1);
        while (idx < cnt && guard < 5000) begin
            op_valid = ($urandom_range(99) < vpct);
            op_data  = op_valid ? ops[idx] : rnd_op();
            start    = $urandom_range(1);
            op_cnt   = CW'($urandom);
            if (op_valid && op_ready) begin
                true_sum = true_sum + 64'(ops[idx]);
                idx++;
            end
            tick();
            guard++;
        end
        chk({tag, "/timeout"}, 64'(guard >= 5000), 0);
        start    = 1'b0;
        op_valid = 1'b1;
        op_data  = rnd_op();
        // One edge after the last accept: resolving, no result yet.
        chk({tag, "/resolve_no_valid"}, res_valid, 0);
        chk({tag, "/resolve_no_ready"}, op_ready, 0);
        tick();
        chk({tag, "/res_valid"}, res_valid, 1);
        chk({tag, "/res_data"}, 64'(res_data), 64'(true_sum[W-1:0]));
`ifdef CSA_ACC_OVF_EN
        chk({tag, "/ovf"}, ovf, 64'((true_sum >> W) != 0));
`endif
        held   = res_data;
        stable = 1'b1;
        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            op_valid = $urandom_range(1);
            op_data  = rnd_op();
            start    = $urandom_range(1);
            tick();
            if (!res_valid || res_data !== held) stable = 1'b0;
        end
        if (hold > 0) chk({tag, "/held"}, 64'(stable), 1);
        op_valid  = 1'b0;
        start     = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "/idle_valid"}, res_valid, 0);
        chk({tag, "/idle_busy"}, busy, 0);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        op_cnt    = '0;
        clear     = 1'b0;
        op_valid  = 1'b0;
        op_data   = '0;
        res_ready = 1'b0;
        #1;
        chk("reset/busy", busy, 0);
        chk("reset/op_ready", op_ready, 0);
        chk("reset/res_valid", res_valid, 0);
        chk("reset/res_data", 64'(res_data), 0);
`ifdef CSA_ACC_OVF_EN
        chk("reset/ovf", ovf, 0);
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 5 + 7 + 9
        ops = '{W'(5), W'(7), W'(9)};
        run_job("sum3", 3, 100, 0);

        // Empty job goes straight to RESOLVE; op_ready must never rise.
        start  = 1'b1;
        op_cnt = '0;
        tick();
        start = 1'b0;
        chk("cnt0/op_ready_resolve", op_ready, 0);
        chk("cnt0/busy", busy, 1);
        chk("cnt0/no_valid_yet", res_valid, 0);
        tick();
        chk("cnt0/op_ready_done", op_ready, 0);
        chk("cnt0/res_valid", res_valid, 1);
        chk("cnt0/res_data", 64'(res_data), 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("cnt0/idle", busy, 0);

        // Wraparound: (2^41-1) + 1
        ops = '{{W{1'b1}}, W'(1)};
        run_job("wrap", 2, 100, 0);

        // 255 ones with a throttled stream and a stalled consumer.
        ops = {};
        for (int i = 0; i < 255; i++) ops.push_back(W'(1));
        run_job("ones255", 255, 50, 10);

        // Abort after 2 of 4 operands, with an operand offered on the clear cycle.
        start  = 1'b1;
        op_cnt = CW'(4);
        tick();
        start    = 1'b0;
        op_valid = 1'b1;
        op_data  = W'(10);
        tick();
        op_data = W'(20);
        tick();
        clear   = 1'b1;
        op_data = W'(99);
        tick();
        clear    = 1'b0;
        op_valid = 1'b0;
        chk("clear/busy", busy, 0);
        chk("clear/op_ready", op_ready, 0);
        chk("clear/res_valid", res_valid, 0);
        // Clear beats a simultaneous start.
        clear  = 1'b1;
        start  = 1'b1;
        op_cnt = CW'(1);
        tick();
        clear = 1'b0;
        start = 1'b0;
        chk("clear_vs_start/busy", busy, 0);
        ops = '{W'(3)};
        run_job("after_clear", 1, 100, 0);

        // Reset in the middle of ACCUM.
        start  = 1'b1;
        op_cnt = CW'(5);
        tick();
        start    = 1'b0;
        op_valid = 1'b1;
        op_data  = W'(123);
        tick();
        tick();
        op_valid = 1'b0;
        chk("prerst/op_ready", op_ready, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst/busy", busy, 0);
        chk("rst/op_ready", op_ready, 0);
        chk("rst/res_valid", res_valid, 0);
        chk("rst/res_data", 64'(res_data), 0);
`ifdef CSA_ACC_OVF_EN
        chk("rst/ovf", ovf, 0);
`endif
        start  = 1'b1;
        op_cnt = CW'(2);
        tick();
        tick();
        chk("rst/start_ignored", busy, 0);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        chk("rst/released_idle", busy, 0);
        chk("rst/no_result", res_valid, 0);

        // Randomized jobs, back to back.
        for (int j = 0; j < 8; j++) begin
            n   = $urandom_range(1, 9);
            ops = {};
            for (int i = 0; i < n; i++) ops.push_back(rnd_op());
            run_job($sformatf("rand%0d", j), n, $urandom_range(30, 100), $urandom_range(0, 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
